alu_op_sequencer: RTL and testbench

//  Upstream feeder and downstream capture for the Phase 1 ALU. Accepts one operation per

---
 rtl/alu_op_sequencer_pkg.sv | 49 ++++
 rtl/alu_op_sequencer_decoder.sv | 37 +++
 rtl/alu_op_sequencer.sv | 113 +++++++++++
 tb/tb_alu_op_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode encodings,
// one-hot strobe bit positions, FSM state type and the MUL/DIV classifier.
package alu_op_sequencer_pkg;

   localparam int OPC_W  = 5;
   localparam int CTRL_W = 14;

   localparam logic [OPC_W-1:0] OP_ADD   = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB   = 5'b00100;
   localparam logic [OPC_W-1:0] OP_SHR   = 5'b00101;
   localparam logic [OPC_W-1:0] OP_SHRA  = 5'b00110;
   localparam logic [OPC_W-1:0] OP_SHL   = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROR   = 5'b01000;
   localparam logic [OPC_W-1:0] OP_ROL   = 5'b01001;
   localparam logic [OPC_W-1:0] OP_AND   = 5'b01010;
   localparam logic [OPC_W-1:0] OP_OR    = 5'b01011;
   localparam logic [OPC_W-1:0] OP_MUL   = 5'b01111;
   localparam logic [OPC_W-1:0] OP_DIV   = 5'b10000;
   localparam logic [OPC_W-1:0] OP_NEG   = 5'b10001;
   localparam logic [OPC_W-1:0] OP_NOT   = 5'b10010;
   localparam logic [OPC_W-1:0] OP_INCPC = 5'b11111;

   // Bit positions inside alu_ctrl
   localparam int B_ADD   = 0;
   localparam int B_SUB   = 1;
   localparam int B_MUL   = 2;
   localparam int B_DIV   = 3;
   localparam int B_AND   = 4;
   localparam int B_OR    = 5;
   localparam int B_SHR   = 6;
   localparam int B_SHRA  = 7;
   localparam int B_SHL   = 8;
   localparam int B_ROR   = 9;
   localparam int B_ROL   = 10;
   localparam int B_NEG   = 11;
   localparam int B_NOT   = 12;
   localparam int B_INCPC = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic op_is_muldiv(input logic [OPC_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_decoder.sv
// Combinational opcode decoder: 5-bit opcode to one-hot ALU strobes,
// plus MUL/DIV classification and an illegal-opcode flag.
module alu_op_sequencer_decoder
   import alu_op_sequencer_pkg::*;
(
   input  logic [OPC_W-1:0]  opcode_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              is_muldiv_o,
   output logic              illegal_o
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      ctrl_o    = '0;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_ADD:   ctrl_o[B_ADD]   = 1'b1;
         OP_SUB:   ctrl_o[B_SUB]   = 1'b1;
         OP_SHR:   ctrl_o[B_SHR]   = 1'b1;
         OP_SHRA:  ctrl_o[B_SHRA]  = 1'b1;
         OP_SHL:   ctrl_o[B_SHL]   = 1'b1;
         OP_ROR:   ctrl_o[B_ROR]   = 1'b1;
         OP_ROL:   ctrl_o[B_ROL]   = 1'b1;
         OP_AND:   ctrl_o[B_AND]   = 1'b1;
         OP_OR:    ctrl_o[B_OR]    = 1'b1;
         OP_MUL:   ctrl_o[B_MUL]   = 1'b1;
         OP_DIV:   ctrl_o[B_DIV]   = 1'b1;
         OP_NEG:   ctrl_o[B_NEG]   = 1'b1;
         OP_NOT:   ctrl_o[B_NOT]   = 1'b1;
         OP_INCPC: ctrl_o[B_INCPC] = 1'b1;
         default:  illegal_o       = 1'b1;
      endcase
   end

   assign is_muldiv_o = op_is_muldiv(opcode_i);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU feeder/capture: accepts one op per handshake, drives one-hot strobes for
// a settle time, captures the ALU result into z_high/z_low and presents it.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int SETTLE_CYC = 1,
   parameter int MULDIV_CYC = 4
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_chigh,
   input  logic [DATA_W-1:0] alu_clow,
   output logic [DATA_W-1:0] z_high,
   output logic [DATA_W-1:0] z_low,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              illegal_op
);

   localparam int MAX_CYC = (SETTLE_CYC > MULDIV_CYC) ? SETTLE_CYC : MULDIV_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] MULDIV_LD = CNT_W'(MULDIV_CYC - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OPC_W-1:0]    opcode_q;
   logic [DATA_W-1:0]   a_q, b_q, zh_q, zl_q;
   logic [CTRL_W-1:0]   dec_ctrl;
   logic                dec_muldiv, dec_illegal;
   logic                accept, capture;

   // Decoding the latched opcode keeps strobes constant for the whole EXEC window
   alu_op_sequencer_decoder u_dec (
      .opcode_i    (opcode_q),
      .ctrl_o      (dec_ctrl),
      .is_muldiv_o (dec_muldiv),
      .illegal_o   (dec_illegal)
   );

   assign accept  = (state_q == ST_IDLE) && op_valid;
   assign capture = (state_q == ST_EXEC) && (cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_ready   = 1'b0;
      res_valid  = 1'b0;
      alu_ctrl   = '0;
      illegal_op = 1'b0;
      case (state_q)
         ST_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               state_d = ST_EXEC;
               cnt_d   = op_is_muldiv(opcode) ? MULDIV_LD : SETTLE_LD;
            end
         end
         ST_EXEC: begin
            alu_ctrl = dec_ctrl;
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_DONE: begin
            res_valid  = 1'b1;
            illegal_op = dec_illegal;
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         opcode_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         zh_q     <= '0;
         zl_q     <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            opcode_q <= opcode;
            a_q      <= a_in;
            b_q      <= b_in;
         end
         // Illegal ops leave the previous result untouched
         if (capture && !dec_illegal) begin
            zl_q <= alu_clow;
            zh_q <= dec_muldiv ? alu_chigh : '0;
         end
      end
   end

   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign z_high = zh_q;
   assign z_low  = zl_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, timestamp-based
// transaction model compared every cycle, directed literal cases, random traffic.
module tb_alu_op_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        op_valid;
   logic        op_ready;
   logic [4:0]  opcode;
   logic [31:0] a_in, b_in;
   logic [31:0] alu_a, alu_b;
   logic [13:0] alu_ctrl;
   logic [31:0] alu_chigh, alu_clow;
   logic [31:0] z_high, z_low;
   logic        res_valid;
   logic        res_ready;
   logic        illegal_op;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   alu_op_sequencer #(.DATA_W(32), .SETTLE_CYC(1), .MULDIV_CYC(4)) dut (
      .clock      (clock),
      .clear      (clear),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .opcode     (opcode),
      .a_in       (a_in),
      .b_in       (b_in),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_chigh  (alu_chigh),
      .alu_clow   (alu_clow),
      .z_high     (z_high),
      .z_low      (z_low),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .illegal_op (illegal_op)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Strobe bit index of an opcode, -1 when undefined
   function automatic int op_index(input logic [4:0] op);
      case (op)
         5'b00011: return 0;   5'b00100: return 1;   5'b01111: return 2;
         5'b10000: return 3;   5'b01010: return 4;   5'b01011: return 5;
         5'b00101: return 6;   5'b00110: return 7;   5'b00111: return 8;
         5'b01000: return 9;   5'b01001: return 10;  5'b10001: return 11;
         5'b10010: return 12;  5'b11111: return 13;
         default:  return -1;
      endcase
   endfunction

   function automatic logic [13:0] onehot(input logic [4:0] op);
      int idx;
      idx = op_index(op);
      return (idx < 0) ? 14'h0 : (14'h1 << idx);
   endfunction

   function automatic int settle_of(input logic [4:0] op);
      return (op == 5'b01111 || op == 5'b10000) ? 4 : 1;
   endfunction

   // Behavioural ALU: returns {high, low}; single-width ops put junk on high
   function automatic logic [63:0] alu_eval(input int idx, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] lo, q, r;
      int sh;
      sh = int'(b[4:0]);
      lo = '0;
      case (idx)
         0:  lo = a + b;
         1:  lo = a - b;
         2:  return {{32{a[31]}}, a} * {{32{b[31]}}, b};
         3: begin
            if (b == 32'h0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 64'h0;
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         4:  lo = a & b;
         5:  lo = a | b;
         6:  lo = a >> sh;
         7:  lo = $signed(a) >>> sh;
         8:  lo = a << sh;
         9:  lo = (a >> sh) | (a << (32 - sh));
         10: lo = (a << sh) | (a >> (32 - sh));
         11: lo = 32'h0 - a;
         12: lo = ~a;
         13: lo = a + 32'd1;
         default: return 64'h0;
      endcase
      return {~lo, lo};
   endfunction

   always_comb begin : alu_model
      int idx;
      logic [63:0] res;
      idx = -1;
      for (int i = 13; i >= 0; i--) if (alu_ctrl[i]) idx = i;
      res       = alu_eval(idx, alu_a, alu_b);
      alu_chigh = res[63:32];
      alu_clow  = res[31:0];
   end

   // Transaction model: an op accepted at edge count k shows strobes until
   // edge k+N, then the result is visible until the consuming edge.
   int          cyc   = 0;
   bit          pend  = 1'b0;
   int          t_res = 0;
   logic [4:0]  m_op  = '0;
   logic [31:0] m_a = '0, m_b = '0, m_zh = '0, m_zl = '0;
   bit          m_ill = 1'b0;
   int          n_accepts = 0;

   always @(posedge clock) begin : model_step
      bit ready_pre, valid_pre;
      int idx;
      logic [63:0] r;
      ready_pre = !pend;
      valid_pre = pend && (cyc >= t_res);
      cyc++;
      if (clear) begin
         if (ready_pre && op_valid) begin
            pend  = 1'b1;
            m_op  = opcode;
            m_a   = a_in;
            m_b   = b_in;
            t_res = cyc + settle_of(opcode);
            n_accepts++;
         end else if (valid_pre && res_ready) begin
            pend = 1'b0;
         end
         if (pend && cyc == t_res) begin
            idx   = op_index(m_op);
            m_ill = (idx < 0);
            if (idx >= 0) begin
               r    = alu_eval(idx, m_a, m_b);
               m_zl = r[31:0];
               m_zh = (idx == 2 || idx == 3) ? r[63:32] : 32'h0;
            end
         end
      end
   end

   always @(negedge clear) begin
      pend = 1'b0;
      m_a  = '0;
      m_b  = '0;
      m_zh = '0;
      m_zl = '0;
   end

   always @(negedge clock) begin : compare
      bit exec, done;
      if (cmp_en) begin
         exec = pend && (cyc < t_res);
         done = pend && (cyc >= t_res);
         check("op_ready",   op_ready,   !pend);
         check("alu_ctrl",   alu_ctrl,   exec ? onehot(m_op) : 14'h0);
         check("alu_a",      alu_a,      m_a);
         check("alu_b",      alu_b,      m_b);
         check("res_valid",  res_valid,  done);
         check("z_high",     z_high,     m_zh);
         check("z_low",      z_low,      m_zl);
         check("illegal_op", illegal_op, done && m_ill);
      end
   end

   // Issues one op from IDLE and returns once res_valid is seen (result not yet consumed)
   task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [13:0] ctrl_seen);
      int k;
      op_valid  = 1'b1;
      opcode    = op;
      a_in      = a;
      b_in      = b;
      res_ready = 1'b0;
      k = 0;
      while (!op_ready && k < 50) begin
         @(posedge clock); #1;
         k++;
      end
      check("accept_wait_ok", k < 50, 1'b1);
      @(posedge clock); #1;
      ctrl_seen = alu_ctrl;
      lat = 0;
      while (!res_valid && lat < 50) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic release_op(input int stall, input bit keep_valid);
      op_valid = keep_valid;
      for (int i = 0; i < stall; i++) begin
         check("stall_op_ready", op_ready, 1'b0);
         check("stall_ctrl", alu_ctrl, 14'h0);
         @(posedge clock); #1;
      end
      res_ready = 1'b1;
      @(posedge clock); #1;
      res_ready = 1'b0;
      op_valid  = 1'b0;
      check("ready_after_handshake", op_ready, 1'b1);
   endtask

   logic [4:0] legal_ops [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                  5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                  5'b10000, 5'b10001, 5'b10010, 5'b11111};

   initial begin
      int lat;
      logic [13:0] cs;
      clear = 1'b0; op_valid = 1'b0; opcode = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
      #2;
      check("rst_alu_ctrl", alu_ctrl, 14'h0);
      check("rst_alu_a", alu_a, 32'h0);
      check("rst_z_low", z_low, 32'h0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_illegal", illegal_op, 1'b0);
      repeat (3) @(posedge clock);
      #1 clear = 1'b1;
      cmp_en = 1'b1;
      #1 check("ready_out_of_reset", op_ready, 1'b1);

      start_op(5'b00011, 32'd5, 32'd7, lat, cs);
      check("add_ctrl", cs, 14'h0001);
      check("add_latency", lat, 1);
      check("add_z_low", z_low, 32'd12);
      check("add_z_high", z_high, 32'h0);
      check("add_illegal", illegal_op, 1'b0);
      release_op(0, 1'b0);

      start_op(5'b01111, 32'd3, 32'hFFFF_FFFE, lat, cs);
      check("mul_ctrl", cs, 14'h0004);
      check("mul_latency", lat, 4);
      check("mul_z_high", z_high, 32'hFFFF_FFFF);
      check("mul_z_low", z_low, 32'hFFFF_FFFA);
      release_op(0, 1'b0);

      start_op(5'b10000, 32'd7, 32'd2, lat, cs);
      check("div_ctrl", cs, 14'h0008);
      check("div_latency", lat, 4);
      check("div_z_high", z_high, 32'd1);
      check("div_z_low", z_low, 32'd3);
      release_op(0, 1'b0);

      start_op(5'b00001, 32'd99, 32'd98, lat, cs);
      check("ill_ctrl", cs, 14'h0);
      check("ill_latency", lat, 1);
      check("ill_flag", illegal_op, 1'b1);
      check("ill_z_high_held", z_high, 32'd1);
      check("ill_z_low_held", z_low, 32'd3);
      release_op(0, 1'b0);

      start_op(5'b00011, 32'd1, 32'd2, lat, cs);
      check("stall_z_low", z_low, 32'd3);
      release_op(5, 1'b1);
      check("stall_z_low_after", z_low, 32'd3);

      // clear during the second MUL EXEC cycle
      op_valid = 1'b1; opcode = 5'b01111; a_in = 32'd9; b_in = 32'd9;
      @(posedge clock); #1;
      op_valid = 1'b0;
      check("mul_exec1_ctrl", alu_ctrl, 14'h0004);
      @(posedge clock); #1;
      check("mul_exec2_ctrl", alu_ctrl, 14'h0004);
      clear = 1'b0;
      #1;
      check("clear_ctrl", alu_ctrl, 14'h0);
      check("clear_res_valid", res_valid, 1'b0);
      check("clear_z_low", z_low, 32'h0);
      #1 clear = 1'b1;
      @(posedge clock); #1;
      start_op(5'b00011, 32'd10, 32'd20, lat, cs);
      check("post_clear_add", z_low, 32'd30);
      check("post_clear_latency", lat, 1);
      release_op(0, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         @(posedge clock); #1;
         op_valid  = ($urandom_range(0, 2) != 0);
         opcode    = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 13)] : 5'($urandom);
         a_in      = $urandom;
         b_in      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         res_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 149) == 0) begin
            clear = 1'b0;
            #1 clear = 1'b1;
         end
      end

      @(posedge clock); #1;
      op_valid  = 1'b0;
      res_ready = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      check("random_traffic_seen", n_accepts > 200, 1'b1);
      check("drained_idle", op_ready, 1'b1);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
